// File: rtl/pipeline_muldiv_unit_pkg.sv
// Shared RV32M encodings and FSM state type for the iterative multiply/divide unit.
package pipeline_muldiv_unit_pkg;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] FUNCT3_MUL    = 3'b000;
  localparam logic [2:0] FUNCT3_MULH   = 3'b001;
  localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
  localparam logic [2:0] FUNCT3_MULHU  = 3'b011;
  localparam logic [2:0] FUNCT3_DIV    = 3'b100;
  localparam logic [2:0] FUNCT3_DIVU   = 3'b101;
  localparam logic [2:0] FUNCT3_REM    = 3'b110;
  localparam logic [2:0] FUNCT3_REMU   = 3'b111;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} muldiv_state_t;

endpackage

// File: rtl/pipeline_muldiv_unit_if.sv
// EX-stage request / result bundle between the pipeline and the multiply/divide unit.
interface pipeline_muldiv_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            start;
  logic            kill;
  logic [2:0]      funct3;
  logic [XLEN-1:0] operand_a;
  logic [XLEN-1:0] operand_b;
  logic            want_stall;
  logic [XLEN-1:0] result;
  logic            result_valid;

  modport master (
    output start, kill, funct3, operand_a, operand_b,
    input  want_stall, result, result_valid
  );

  modport slave (
    input  start, kill, funct3, operand_a, operand_b,
    output want_stall, result, result_valid
  );
endinterface

// File: rtl/pipeline_muldiv_unit.sv
// Iterative RV32M multiply/divide: one shift-add or restoring shift-subtract step per cycle,
// stalling the pipeline until the result is presented.
module pipeline_muldiv_unit
  import pipeline_muldiv_unit_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input logic                   clock,
  input logic                   reset,
  pipeline_muldiv_unit_if.slave bus_io
);

  localparam int unsigned     CntW    = $clog2(XLEN);
  localparam logic [CntW-1:0] CntLast = CntW'(XLEN - 1);

  muldiv_state_t   state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] acc_q, acc_d;      // product high half / partial remainder
  logic [XLEN-1:0] mq_q, mq_d;        // multiplier / dividend-then-quotient
  logic [XLEN-1:0] opb_q, opb_d;      // multiplicand / divisor magnitude
  logic [2:0]      f3_q, f3_d;
  logic            sign_a_q, sign_a_d, sign_b_q, sign_b_d;
  logic [XLEN-1:0] result_q, result_d;

  logic [2:0]      f3;
  logic            a_signed, b_signed, neg_a, neg_b, div_zero, div_ovf;
  logic [XLEN-1:0] mag_a, mag_b, special_res;

  always_comb begin
    f3       = bus_io.funct3;
    a_signed = (f3 == FUNCT3_MULH) || (f3 == FUNCT3_MULHSU) ||
               (f3 == FUNCT3_DIV)  || (f3 == FUNCT3_REM);
    b_signed = (f3 == FUNCT3_MULH) || (f3 == FUNCT3_DIV) || (f3 == FUNCT3_REM);
    neg_a    = a_signed && bus_io.operand_a[XLEN-1];
    neg_b    = b_signed && bus_io.operand_b[XLEN-1];
    mag_a    = neg_a ? ('0 - bus_io.operand_a) : bus_io.operand_a;
    mag_b    = neg_b ? ('0 - bus_io.operand_b) : bus_io.operand_b;
    div_zero = f3[2] && (bus_io.operand_b == '0);
    div_ovf  = ((f3 == FUNCT3_DIV) || (f3 == FUNCT3_REM)) &&
               (bus_io.operand_a == {1'b1, {(XLEN-1){1'b0}}}) && (bus_io.operand_b == '1);
    // f3[1] separates REM/REMU from DIV/DIVU
    if (div_zero) special_res = f3[1] ? bus_io.operand_a : '1;
    else          special_res = f3[1] ? '0 : bus_io.operand_a;
  end

  // Shared adder: acc + multiplicand for mul, shifted remainder - divisor for div.
  logic            is_div;
  logic [XLEN:0]   shifted, add_a, add_b, mul_sum;
  logic [XLEN+1:0] sum;
  logic [XLEN-1:0] step_acc, step_mq;

  always_comb begin
    is_div  = f3_q[2];
    shifted = {acc_q, mq_q[XLEN-1]};
    add_a   = is_div ? shifted : {1'b0, acc_q};
    add_b   = is_div ? ~{1'b0, opb_q} : {1'b0, opb_q};
    sum     = {1'b0, add_a} + {1'b0, add_b} + {{(XLEN+1){1'b0}}, is_div};
    mul_sum = mq_q[0] ? sum[XLEN:0] : {1'b0, acc_q};
    if (is_div) begin
      step_acc = sum[XLEN+1] ? sum[XLEN-1:0] : shifted[XLEN-1:0];
      step_mq  = {mq_q[XLEN-2:0], sum[XLEN+1]};
    end else begin
      step_acc = mul_sum[XLEN:1];
      step_mq  = {mul_sum[0], mq_q[XLEN-1:1]};
    end
  end

  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot_fix, rem_fix, final_res;

  always_comb begin
    prod_fix = (sign_a_q ^ sign_b_q) ? ('0 - {step_acc, step_mq}) : {step_acc, step_mq};
    quot_fix = (sign_a_q ^ sign_b_q) ? ('0 - step_mq) : step_mq;
    rem_fix  = sign_a_q ? ('0 - step_acc) : step_acc;
    unique case (f3_q)
      FUNCT3_MUL:                 final_res = prod_fix[XLEN-1:0];
      FUNCT3_DIV, FUNCT3_DIVU:    final_res = quot_fix;
      FUNCT3_REM, FUNCT3_REMU:    final_res = rem_fix;
      default:                    final_res = prod_fix[2*XLEN-1:XLEN];
    endcase
  end

  always_comb begin
    state_d           = state_q;
    cnt_d             = cnt_q;
    acc_d             = acc_q;
    mq_d              = mq_q;
    opb_d             = opb_q;
    f3_d              = f3_q;
    sign_a_d          = sign_a_q;
    sign_b_d          = sign_b_q;
    result_d          = result_q;
    bus_io.want_stall = 1'b0;
    unique case (state_q)
      IDLE: begin
        bus_io.want_stall = bus_io.start && !bus_io.kill;
        if (bus_io.start && !bus_io.kill) begin
          f3_d     = f3;
          sign_a_d = neg_a;
          sign_b_d = neg_b;
          acc_d    = '0;
          mq_d     = f3[2] ? mag_a : mag_b;
          opb_d    = f3[2] ? mag_b : mag_a;
          cnt_d    = '0;
          if (div_zero || div_ovf) begin
            result_d = special_res;
            state_d  = DONE;
          end else begin
            state_d  = BUSY;
          end
        end
      end
      BUSY: begin
        bus_io.want_stall = 1'b1;
        acc_d             = step_acc;
        mq_d              = step_mq;
        cnt_d             = cnt_q + CntW'(1);
        if (cnt_q == CntLast) begin
          result_d = final_res;
          cnt_d    = '0;
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (bus_io.kill) begin
      state_d  = IDLE;
      cnt_d    = '0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mq_q     <= '0;
      opb_q    <= '0;
      f3_q     <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mq_q     <= mq_d;
      opb_q    <= opb_d;
      f3_q     <= f3_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      result_q <= result_d;
    end
  end

  assign bus_io.result       = result_q;
  assign bus_io.result_valid = (state_q == DONE);

endmodule

// File: tb/tb_pipeline_muldiv_unit.sv
// Scoreboard bench for pipeline_muldiv_unit: directed RV32M cases, kill/reset aborts, random ops.
module tb_pipeline_muldiv_unit;

  logic clock = 1'b0;
  logic reset = 1'b0;

  pipeline_muldiv_unit_if #(.XLEN(32)) bus ();

  pipeline_muldiv_unit #(.XLEN(32)) dut (
    .clock  (clock),
    .reset  (reset),
    .bus_io (bus)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  int          tag_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [63:0] sa, sb;
    logic [63:0]        ua, ub, p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (f)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin if (b == 0) return 32'hFFFF_FFFF; p = ua / ub; return p[31:0]; end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] f, input logic [31:0] a,
                                    input logic [31:0] b);
    if (f[2] && b == 0) return 1'b1;
    return (f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
  endfunction

  // Monitor: every result_valid pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (reset && bus.result_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid got=%h expected=no result at %0t", bus.result, $time);
      end else begin
        automatic logic [31:0] e = exp_q.pop_front();
        automatic int          t = tag_q.pop_front();
        check($sformatf("result_f3_%0d", t), bus.result, e);
        check("stall_in_done", {31'b0, bus.want_stall}, 32'd0);
      end
    end
  end

  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    int stall = 0;
    bit seen  = 1'b0;
    @(posedge clock); #1;
    bus.start     = 1'b1;
    bus.kill      = 1'b0;
    bus.funct3    = f;
    bus.operand_a = a;
    bus.operand_b = b;
    exp_q.push_back(model(f, a, b));
    tag_q.push_back(int'(f));
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clock);
      if (bus.want_stall) stall++;
      if (bus.result_valid) seen = 1'b1;
      // Operands are only sampled at acceptance; scribble on them while busy.
      if (i == 5) begin
        bus.operand_a = $urandom;
        bus.operand_b = $urandom;
      end
    end
    check("done_seen", {31'b0, seen}, 32'd1);
    check("stall_cycles", stall, is_special(f, a, b) ? 32'd1 : 32'd33);
  endtask

  task automatic go_idle();
    @(posedge clock); #1;
    bus.start = 1'b0;
    bus.kill  = 1'b0;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int bad_valid;
    bus.start     = 1'b0;
    bus.kill      = 1'b0;
    bus.funct3    = 3'd0;
    bus.operand_a = '0;
    bus.operand_b = '0;
    #1;
    check("reset_result", bus.result, 32'd0);
    check("reset_valid", {31'b0, bus.result_valid}, 32'd0);
    check("reset_stall", {31'b0, bus.want_stall}, 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;

    // Directed cases
    run_op(3'd0, 32'd7, 32'hFFFF_FFFD);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(3'd2, 32'hFFFF_FFFF, 32'd2);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2);
    run_op(3'd5, 32'd100, 32'd7);
    run_op(3'd7, 32'd100, 32'd7);
    run_op(3'd4, 32'd5, 32'd0);
    run_op(3'd6, 32'd5, 32'd0);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
    // Back-to-back multiplies
    run_op(3'd0, 32'd123, 32'd456);
    run_op(3'd0, 32'hDEAD_BEEF, 32'h1234_5678);
    go_idle();

    // start with kill in IDLE must neither stall nor launch
    @(posedge clock); #1;
    bus.start = 1'b1; bus.kill = 1'b1; bus.funct3 = 3'd0;
    #1 check("kill_idle_stall", {31'b0, bus.want_stall}, 32'd0);
    go_idle();
    @(negedge clock);
    check("kill_idle_no_launch", {30'b0, bus.want_stall, bus.result_valid}, 32'd0);

    // kill at BUSY counter=10
    @(posedge clock); #1;
    bus.start = 1'b1; bus.funct3 = 3'd0; bus.operand_a = 32'd9; bus.operand_b = 32'd9;
    repeat (11) @(posedge clock);
    #1 bus.kill = 1'b1; bus.start = 1'b0;
    @(posedge clock); #1 bus.kill = 1'b0;
    @(negedge clock);
    check("kill_stall_after", {31'b0, bus.want_stall}, 32'd0);
    check("kill_valid_after", {31'b0, bus.result_valid}, 32'd0);
    bad_valid = 0;
    repeat (40) begin
      @(negedge clock);
      if (bus.result_valid) bad_valid++;
    end
    check("kill_no_result", bad_valid, 32'd0);

    // reset at BUSY counter=20 (previous result is nonzero)
    @(posedge clock); #1;
    bus.start = 1'b1; bus.funct3 = 3'd5; bus.operand_a = 32'd1000; bus.operand_b = 32'd3;
    repeat (21) @(posedge clock);
    #1 bus.start = 1'b0; reset = 1'b0;
    #1;
    check("midreset_result", bus.result, 32'd0);
    check("midreset_valid", {31'b0, bus.result_valid}, 32'd0);
    check("midreset_stall", {31'b0, bus.want_stall}, 32'd0);
    @(negedge clock);
    reset = 1'b1;

    // Random operations
    for (int n = 0; n < 40; n++) begin
      run_op(3'($urandom_range(0, 7)), pick(), pick());
      if ($urandom_range(0, 1) == 1) go_idle();
    end
    go_idle();

    repeat (3) @(negedge clock);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
